// File: rtl/unary_div_src.sv
// Unary bitstream source for a stochastic divider: converts binary dividend/divisor
// into LFSR-compared and counter-compared unary streams plus the divider's random number.
module unary_div_src #(
    parameter int       DEP    = 5,
    parameter [DEP-1:0] SEED_A = 5'h01,
    parameter [DEP-1:0] SEED_B = 5'h15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           en,
    input  logic [DEP-1:0] dividend_bin,
    input  logic [DEP-1:0] divisor_bin,
    output logic           dividend,
    output logic           divisor,
    output logic [DEP-1:0] randNum,
    output logic           valid,
    output logic           last,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DEP-1:0] ONE      = {{(DEP-1){1'b0}}, 1'b1};
    localparam logic [DEP-1:0] SA       = (SEED_A == '0) ? ONE : SEED_A;
    localparam logic [DEP-1:0] SB       = (SEED_B == '0) ? ONE : SEED_B;
    localparam logic [DEP:0]   CNT_LAST = {1'b0, {DEP{1'b1}}};

    // Maximal-length tap masks, one per supported width
    localparam logic [7:0] TAPS = (DEP == 4) ? 8'h0C :
                                  (DEP == 5) ? 8'h14 :
                                  (DEP == 6) ? 8'h30 :
                                  (DEP == 7) ? 8'h60 : 8'hB8;
    localparam logic [DEP-1:0] TAP_MASK = TAPS[DEP-1:0];

    logic [1:0]     state;
    logic [DEP-1:0] op_a;
    logic [DEP-1:0] op_b;
    logic [DEP-1:0] lfsr_a;
    logic [DEP-1:0] lfsr_b;
    logic [DEP:0]   cnt;
    logic [DEP-1:0] cnt_rev;
    logic           fb_a;
    logic           fb_b;
    logic           at_last;

    assign fb_a    = ^(lfsr_a & TAP_MASK);
    assign fb_b    = ^(lfsr_b & TAP_MASK);
    assign at_last = (cnt == CNT_LAST);

    always_comb begin
        cnt_rev = '0;
        for (int unsigned i = 0; i < DEP; i++) begin
            cnt_rev[i] = cnt[DEP-1-i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            cnt    <= '0;
            lfsr_a <= SA;
            lfsr_b <= SB;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= dividend_bin;
                        op_b   <= divisor_bin;
                        lfsr_a <= SA;
                        lfsr_b <= SB;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        lfsr_a <= {lfsr_a[DEP-2:0], fb_a};
                        lfsr_b <= {lfsr_b[DEP-2:0], fb_b};
                        cnt    <= cnt + 1'b1;
                        if (at_last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stream bits stay decoded from held state during a stall; only valid drops
    always_comb begin
        dividend = 1'b0;
        divisor  = 1'b0;
        randNum  = '0;
        valid    = 1'b0;
        last     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            RUN: begin
                busy     = 1'b1;
                valid    = en;
                dividend = (op_a > lfsr_a);
                divisor  = (op_b > cnt_rev);
                randNum  = lfsr_b;
                last     = en && at_last;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unary_div_src.sv
// Directed, table-driven bench for unary_div_src at DEP=5 with default seeds.
module tb_unary_div_src;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [4:0] dividend_bin = '0;
    logic [4:0] divisor_bin = '0;
    logic       dividend, divisor, valid, last, busy, done;
    logic [4:0] randNum;

    int checks = 0;
    int failures = 0;

    logic [6:0] cur_s [32];
    logic [6:0] ref_s [32];

    unary_div_src #(.DEP(5), .SEED_A(5'h01), .SEED_B(5'h15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en(en),
        .dividend_bin(dividend_bin), .divisor_bin(divisor_bin),
        .dividend(dividend), .divisor(divisor), .randNum(randNum),
        .valid(valid), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        int         exp_a;
        int         exp_b;
    } run_vec_t;

    typedef struct {
        logic       dvd;
        logic       dvs;
        logic [4:0] rn;
    } bit_vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {dividend, divisor, randNum, valid, last, busy, done};
    endfunction

    task automatic do_run(input logic [4:0] a, input logic [4:0] b,
                          input int stall_at, input int stall_len,
                          input bit disturb, input bit abort10,
                          output int vcnt, output int ones_a, output int ones_b,
                          output int busy_n, output int done_n,
                          output int last_pos, output int done_cyc);
        int         stalled = 0;
        bit         have_frozen = 0;
        logic [6:0] frozen = '0;
        logic [6:0] now_s;
        vcnt = 0; ones_a = 0; ones_b = 0; busy_n = 0; done_n = 0;
        last_pos = -1; done_cyc = -1;
        @(posedge clk); #1;
        dividend_bin = a; divisor_bin = b; start = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; dividend_bin = ~a; divisor_bin = ~b;
        for (int cyc = 0; cyc < 100; cyc++) begin
            en = !(vcnt == stall_at && stalled < stall_len);
            if (!en) stalled++;
            start = disturb && (cyc == 8);
            if (disturb && cyc == 8) dividend_bin = 5'd0;
            if (abort10 && cyc == 10) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outputs_zero", int'(all_outs()), 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                start = 1'b0;
                en = 1'b0;
                return;
            end
            #1;
            now_s = {dividend, divisor, randNum};
            if (cyc == 0) chk("first_valid_latency", int'(valid), 1);
            if (done) begin
                done_n++;
                done_cyc = cyc;
                chk("done_cycle_quiet", int'({valid, busy, last}), 0);
                break;
            end
            if (busy) busy_n++;
            if (valid) begin
                if (have_frozen && vcnt == stall_at)
                    chk("stall_resume_value", int'(now_s), int'(frozen));
                if (vcnt < 32) cur_s[vcnt] = now_s;
                ones_a += int'(dividend);
                ones_b += int'(divisor);
                if (last) last_pos = vcnt + 1;
                vcnt++;
            end else if (busy) begin
                if (!have_frozen) begin
                    frozen = now_s;
                    have_frozen = 1;
                end else begin
                    chk("stall_frozen", int'(now_s), int'(frozen));
                end
                chk("stall_last_low", int'(last), 0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        en = 1'b0;
    endtask

    run_vec_t runs [6];
    bit_vec_t first_bits [6];

    initial begin
        int vcnt, oa, ob, bn, dn, lp, dc;
        int mism;
        logic [10:0] acc;

        runs[0] = '{a: 5'd16, b: 5'd24, exp_a: 16, exp_b: 24};
        runs[1] = '{a: 5'd31, b: 5'd0,  exp_a: 31, exp_b: 0};
        runs[2] = '{a: 5'd0,  b: 5'd31, exp_a: 0,  exp_b: 31};
        runs[3] = '{a: 5'd1,  b: 5'd1,  exp_a: 0,  exp_b: 1};
        runs[4] = '{a: 5'd2,  b: 5'd5,  exp_a: 2,  exp_b: 5};
        runs[5] = '{a: 5'd7,  b: 5'd13, exp_a: 7,  exp_b: 13};

        // A=16, B=24: lfsr_a 01,02,04,09,12,05; rev(cnt) 0,16,8,24,4,20; lfsr_b 15,0A,14,08,10,01
        first_bits[0] = '{dvd: 1'b1, dvs: 1'b1, rn: 5'h15};
        first_bits[1] = '{dvd: 1'b1, dvs: 1'b1, rn: 5'h0A};
        first_bits[2] = '{dvd: 1'b1, dvs: 1'b1, rn: 5'h14};
        first_bits[3] = '{dvd: 1'b1, dvs: 1'b0, rn: 5'h08};
        first_bits[4] = '{dvd: 1'b0, dvs: 1'b1, rn: 5'h10};
        first_bits[5] = '{dvd: 1'b1, dvs: 1'b1, rn: 5'h01};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", int'(all_outs()), 0);
        rst_n = 1'b1;
        acc = '0;
        repeat (4) begin
            @(posedge clk); #1;
            acc |= all_outs();
        end
        chk("idle_after_reset", int'(acc), 0);

        for (int i = 0; i < 6; i++) begin
            do_run(runs[i].a, runs[i].b, -1, 0, 1'b0, 1'b0, vcnt, oa, ob, bn, dn, lp, dc);
            chk($sformatf("run%0d_valid_count", i), vcnt, 32);
            chk($sformatf("run%0d_dividend_ones", i), oa, runs[i].exp_a);
            chk($sformatf("run%0d_divisor_ones", i), ob, runs[i].exp_b);
            chk($sformatf("run%0d_last_pos", i), lp, 32);
            chk($sformatf("run%0d_done_count", i), dn, 1);
            chk($sformatf("run%0d_done_cycle", i), dc, 32);
            chk($sformatf("run%0d_busy_cycles", i), bn, 32);
            if (i == 0) for (int k = 0; k < 32; k++) ref_s[k] = cur_s[k];
        end

        for (int k = 0; k < 6; k++)
            chk($sformatf("first_bits_%0d", k), int'(ref_s[k]),
                int'({first_bits[k].dvd, first_bits[k].dvs, first_bits[k].rn}));

        do_run(5'd16, 5'd24, 12, 5, 1'b0, 1'b0, vcnt, oa, ob, bn, dn, lp, dc);
        chk("stall_valid_count", vcnt, 32);
        chk("stall_busy_cycles", bn, 37);
        chk("stall_dividend_ones", oa, 16);
        chk("stall_divisor_ones", ob, 24);
        chk("stall_done_cycle", dc, 37);

        do_run(5'd16, 5'd24, -1, 0, 1'b1, 1'b0, vcnt, oa, ob, bn, dn, lp, dc);
        chk("ignored_valid_count", vcnt, 32);
        chk("ignored_dividend_ones", oa, 16);
        chk("ignored_divisor_ones", ob, 24);
        chk("ignored_done_count", dn, 1);

        do_run(5'd16, 5'd24, -1, 0, 1'b0, 1'b1, vcnt, oa, ob, bn, dn, lp, dc);
        chk("abort_valid_before_reset", vcnt, 10);
        acc = '0;
        repeat (4) begin
            @(posedge clk); #1;
            acc |= all_outs();
        end
        chk("abort_no_done", int'(acc), 0);

        do_run(5'd16, 5'd24, -1, 0, 1'b0, 1'b0, vcnt, oa, ob, bn, dn, lp, dc);
        chk("rerun_valid_count", vcnt, 32);
        mism = 0;
        for (int k = 0; k < 32; k++) if (cur_s[k] !== ref_s[k]) mism++;
        chk("rerun_stream_mismatches", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unary_div_src.md
UNARY_DIV_SRC -- requirements
Module: unary_div_src

Interface
REQ-001 The block SHALL take parameter DEP, default 5, as the binary operand width and random-number width; legal range is 4..8.
REQ-002 The block SHALL take parameter SEED_A, default 5'h01, as the dividend LFSR seed; a value of 0 is replaced by 1.
REQ-003 The block SHALL take parameter SEED_B, default 5'h15, as the randNum LFSR seed; a value of 0 is replaced by 1.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 en  input  1  advance enable; low stalls a run.
REQ-008 dividend_bin  input  DEP  unsigned dividend value, captured on start.
REQ-009 divisor_bin  input  DEP  unsigned divisor value, captured on start.
REQ-010 dividend  output  1  unary dividend bitstream to the divider.
REQ-011 divisor  output  1  unary divisor bitstream to the divider.
REQ-012 randNum  output  DEP  comparator random number for the divider.
REQ-013 valid  output  1  stream bits this cycle are meaningful.
REQ-014 last  output  1  the final valid bit of the run.
REQ-015 busy  output  1  the block is in RUN.
REQ-016 done  output  1  one-cycle pulse after a run completes.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE with start=1 at an edge SHALL load opA=dividend_bin, opB=divisor_bin, lfsr_a=SEED_A, lfsr_b=SEED_B and cnt=0, then enter RUN; en is irrelevant to this transition.
REQ-019 start SHALL be ignored in RUN and DONE, and changes to dividend_bin/divisor_bin after capture SHALL have no effect.
REQ-020 In RUN, valid and busy SHALL both be 1, and dividend, divisor and randNum SHALL be decoded from the current state as follows.
  - dividend = (opA > lfsr_a).
  - divisor = (opB > bitrev(cnt[DEP-1:0])).
  - randNum = lfsr_b.
REQ-021 In RUN with en=1, each edge SHALL advance lfsr_a, lfsr_b and cnt by one step; with en=0, all state SHALL hold and valid SHALL be 0.
REQ-022 The LFSRs SHALL be Fibonacci, left-shifting: next = {lfsr[DEP-2:0], fb}.
REQ-023 The feedback fb SHALL be the XOR of the tap bits selected by DEP.
  - DEP=4: taps 3, 2.
  - DEP=5: taps 4, 2.
  - DEP=6: taps 5, 4.
  - DEP=7: taps 6, 5.
  - DEP=8: taps 7, 5, 4, 3.
REQ-024 With these taps the LFSR period SHALL be 2^DEP-1 and the all-zero state SHALL be unreachable.
REQ-025 cnt SHALL be DEP+1 bits wide, and a run SHALL be exactly 2^DEP enabled cycles.
REQ-026 last SHALL equal valid AND (cnt == 2^DEP-1).
REQ-027 On an edge with last=1, the FSM SHALL enter DONE.
REQ-028 DONE SHALL last one cycle with done=1, busy=0 and valid=0, then return to IDLE.
REQ-029 In IDLE and DONE, dividend, divisor, valid, last and busy SHALL be 0, and randNum SHALL be 0.
REQ-030 Start latency: start sampled at edge k SHALL make the first valid bit appear in the cycle after edge k.
REQ-031 Counts over one run SHALL be exact.
  - Divisor ones = opB.
  - Dividend ones = max(opA-1,0) + (opA > SEED_A).
REQ-032 All outputs SHALL be combinational decodes of registered state and en only, with no other input-to-output path.

Reset
REQ-033 While rst_n=0, the block SHALL hold state=IDLE, opA=opB=0, cnt=0, lfsr_a=SEED_A and lfsr_b=SEED_B.
REQ-034 While rst_n=0, all outputs SHALL be 0.
REQ-035 Asserting rst_n mid-RUN SHALL abort the run immediately with no done pulse, and the next start SHALL reproduce streams identical to a fresh run.

Verification
REQ-036 Reset check: rst_n=0 -> all outputs 0; release with start=0 -> the block stays IDLE and valid remains 0.
REQ-037 Nominal run: DEP=5, start with A=16, B=24, en=1 -> valid high for exactly 32 cycles, last on the 32nd, done the next cycle; divisor ones=24, dividend ones=16.
REQ-038 Extreme operands: A=31, B=0 -> dividend ones=31, divisor stays 0 for all 32 valid cycles; A=0 -> dividend ones=0.
REQ-039 Stall: en=0 for 5 cycles mid-run -> valid low and outputs frozen during the stall, busy high for 37 cycles, ones counts unchanged from REQ-037.
REQ-040 Ignored inputs: start pulse and dividend_bin change during RUN -> no restart, run length stays 32, counts reflect the captured operands.
REQ-041 Mid-run reset: rst_n pulse at cycle 10 of a run -> outputs 0 immediately, no done; a new start yields a bit-for-bit identical stream to the first run.
